// File: rtl/secure_reg_req_arbiter.sv
// Request stage in front of secure_register: buffers thread requests in a FIFO,
// issues them one at a time under the thread-0-only policy and returns one response each.
module secure_reg_req_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TID_WIDTH  = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_VIOL   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [TID_WIDTH-1:0]  req_thread_id,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  reg_access_en,
    output logic                  reg_wr_en,
    output logic [TID_WIDTH-1:0]  reg_thread_id,
    output logic [DATA_WIDTH-1:0] reg_data_in,
    input  logic [DATA_WIDTH-1:0] reg_data_out,
    output logic [7:0]            viol_count,
    output logic                  locked
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned VIOL_W = 8;

    typedef struct packed {
        logic                  write;
        logic [TID_WIDTH-1:0]  tid;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    req_t                  fifo_q [FIFO_DEPTH];
    req_t                  req_in;
    req_t                  head;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push;
    logic                  pop;
    logic                  auth_head;
    logic                  cur_write_q, cur_write_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;
    logic                  access_en_q, access_en_d;
    logic                  wr_en_q, wr_en_d;
    logic [TID_WIDTH-1:0]  reg_tid_q, reg_tid_d;
    logic [DATA_WIDTH-1:0] reg_din_q, reg_din_d;
    logic [VIOL_W-1:0]     viol_q, viol_d;
    logic [VIOL_W-1:0]     viol_inc;
    logic                  locked_q, locked_d;

    assign req_in    = '{write: req_write, tid: req_thread_id, wdata: req_wdata};
    assign head      = fifo_q[rd_ptr_q];
    assign push      = req_valid & req_ready_q;
    assign auth_head = (head.tid == '0) && !locked_q;

    // FIFO payload storage; flushing is done through the pointers only
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= req_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            cur_write_q  <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            access_en_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            reg_tid_q    <= '0;
            reg_din_q    <= '0;
            viol_q       <= '0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            cur_write_q  <= cur_write_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            access_en_q  <= access_en_d;
            wr_en_q      <= wr_en_d;
            reg_tid_q    <= reg_tid_d;
            reg_din_q    <= reg_din_d;
            viol_q       <= viol_d;
            locked_q     <= locked_d;
        end
    end

    // Strobes are registered, so they are set on the IDLE->ISSUE transition and
    // are high for exactly the ISSUE cycle.
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        cur_write_d  = cur_write_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        access_en_d  = 1'b0;
        wr_en_d      = 1'b0;
        reg_tid_d    = reg_tid_q;
        reg_din_d    = reg_din_q;
        viol_d       = viol_q;
        locked_d     = locked_q;
        viol_inc     = (viol_q == '1) ? viol_q : viol_q + VIOL_W'(1);

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d     = S_ISSUE;
                    access_en_d = auth_head;
                    wr_en_d     = auth_head & head.write;
                    if (auth_head) begin
                        reg_tid_d = head.tid;
                        reg_din_d = head.wdata;
                    end
                end
            end
            S_ISSUE: begin
                pop         = 1'b1;
                cur_write_d = head.write;
                if (access_en_q) begin
                    state_d = S_WAIT;
                end else begin
                    viol_d       = viol_inc;
                    locked_d     = locked_q | (viol_inc >= VIOL_W'(MAX_VIOL));
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                end
            end
            S_WAIT: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = cur_write_q ? '0 : reg_data_out;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        req_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;
    assign reg_access_en = access_en_q;
    assign reg_wr_en     = wr_en_q;
    assign reg_thread_id = reg_tid_q;
    assign reg_data_in   = reg_din_q;
    assign viol_count    = viol_q;
    assign locked        = locked_q;

endmodule

// File: tb/tb_secure_reg_req_arbiter.sv
// Directed bench for secure_reg_req_arbiter with a small secure_register stand-in.
module tb_secure_reg_req_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_thread_id;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        reg_access_en, reg_wr_en;
    logic [3:0]  reg_thread_id;
    logic [31:0] reg_data_in, reg_data_out;
    logic [7:0]  viol_count;
    logic        locked;

    int vecs = 0;
    int errs = 0;
    int strobes = 0;
    int bad_strobes = 0;
    logic [31:0] mem_q = '0;
    logic [31:0] rdo_q = '0;

    secure_reg_req_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_wdata(req_wdata), .req_thread_id(req_thread_id),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .reg_access_en(reg_access_en), .reg_wr_en(reg_wr_en),
        .reg_thread_id(reg_thread_id), .reg_data_in(reg_data_in),
        .reg_data_out(reg_data_out),
        .viol_count(viol_count), .locked(locked)
    );

    always #5 clk = ~clk;

    // Register stand-in: read data appears one cycle after the strobe
    assign reg_data_out = rdo_q;
    always @(posedge clk) begin
        if (reg_access_en) begin
            strobes <= strobes + 1;
            if (reg_wr_en) mem_q <= reg_data_in;
            else           rdo_q <= mem_q;
        end
        if (reg_wr_en && !reg_access_en) bad_strobes <= bad_strobes + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic w, input logic [3:0] tid, input logic [31:0] d);
        int n = 0;
        req_valid = 1'b1; req_write = w; req_thread_id = tid; req_wdata = d;
        while (!req_ready && n < 50) begin tick(); n++; end
        if (!req_ready) begin
            vecs++; errs++;
            $display("FAIL send_timeout req_ready=%0b required 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp;
        int n = 0;
        while (!resp_valid && n < 50) begin tick(); n++; end
        if (!resp_valid) begin
            vecs++; errs++;
            $display("FAIL resp_timeout resp_valid=%0b required 1", resp_valid);
        end
    endtask

    task automatic test_reset;
        do_reset();
        vecs++;
        if ({req_ready, resp_valid, resp_err, locked, reg_access_en, reg_wr_en} !== 6'b100000) begin
            errs++;
            $display("FAIL reset_flags got %b required 100000",
                     {req_ready, resp_valid, resp_err, locked, reg_access_en, reg_wr_en});
        end
        vecs++;
        if ({viol_count, resp_rdata, reg_data_in} !== 72'h0) begin
            errs++;
            $display("FAIL reset_values viol=%0h rdata=%0h din=%0h required 0", viol_count, resp_rdata, reg_data_in);
        end
    endtask

    task automatic test_authorised;
        do_reset();
        send(1'b1, 4'd0, 32'hDEADBEEF);
        tick();
        vecs++;
        if ({reg_access_en, reg_wr_en, reg_thread_id, reg_data_in} !== {1'b1, 1'b1, 4'd0, 32'hDEADBEEF}) begin
            errs++;
            $display("FAIL wr_strobe en=%b wr=%b tid=%0h din=%h required 1 1 0 deadbeef",
                     reg_access_en, reg_wr_en, reg_thread_id, reg_data_in);
        end
        tick();
        vecs++;
        if ({resp_valid, reg_access_en} !== 2'b00) begin
            errs++;
            $display("FAIL wr_cycle3 valid=%b en=%b required 0 0", resp_valid, reg_access_en);
        end
        tick();
        vecs++;
        if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            errs++;
            $display("FAIL wr_resp valid=%b err=%b rdata=%h required 1 0 00000000", resp_valid, resp_err, resp_rdata);
        end
        resp_ready = 1'b1;
        tick();
        send(1'b0, 4'd0, 32'h0);
        tick();
        vecs++;
        if ({reg_access_en, reg_wr_en} !== 2'b10) begin
            errs++;
            $display("FAIL rd_strobe en=%b wr=%b required 1 0", reg_access_en, reg_wr_en);
        end
        tick();
        vecs++;
        if (resp_valid !== 1'b0) begin
            errs++;
            $display("FAIL rd_early_resp valid=%b required 0", resp_valid);
        end
        tick();
        vecs++;
        if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
            errs++;
            $display("FAIL rd_resp valid=%b err=%b rdata=%h required 1 0 deadbeef", resp_valid, resp_err, resp_rdata);
        end
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_denied;
        int s0;
        do_reset();
        s0 = strobes;
        send(1'b1, 4'd5, 32'h12345678);
        tick();
        tick();
        vecs++;
        if ({resp_valid, resp_err, resp_rdata, viol_count, locked} !== {1'b1, 1'b1, 32'h0, 8'd1, 1'b0}) begin
            errs++;
            $display("FAIL deny_resp valid=%b err=%b rdata=%h viol=%0d locked=%b required 1 1 0 1 0",
                     resp_valid, resp_err, resp_rdata, viol_count, locked);
        end
        vecs++;
        if (strobes !== s0) begin
            errs++;
            $display("FAIL deny_strobes got %0d required %0d", strobes, s0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_lockout;
        int got = 0;
        int s0;
        do_reset();
        resp_ready = 1'b1;
        send(1'b1, 4'd5, 32'h1);
        send(1'b0, 4'd9, 32'h0);
        send(1'b1, 4'd3, 32'h2);
        for (int c = 0; c < 60 && got < 3; c++) begin
            if (resp_valid) begin
                vecs++;
                if ({resp_err, resp_rdata} !== {1'b1, 32'h0}) begin
                    errs++;
                    $display("FAIL lock_deny%0d err=%b rdata=%h required 1 0", got, resp_err, resp_rdata);
                end
                got++;
            end
            tick();
        end
        vecs++;
        if ({got[3:0], viol_count, locked} !== {4'd3, 8'd3, 1'b1}) begin
            errs++;
            $display("FAIL lock_set resps=%0d viol=%0d locked=%b required 3 3 1", got, viol_count, locked);
        end
        s0 = strobes;
        resp_ready = 1'b0;
        send(1'b0, 4'd0, 32'h0);
        wait_resp();
        vecs++;
        if ({resp_err, resp_rdata, viol_count, locked} !== {1'b1, 32'h0, 8'd4, 1'b1} || strobes !== s0) begin
            errs++;
            $display("FAIL lock_t0 err=%b rdata=%h viol=%0d locked=%b strobes=%0d required 1 0 4 1 %0d",
                     resp_err, resp_rdata, viol_count, locked, strobes, s0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_fifo_full;
        logic        exp_err [6];
        logic [31:0] exp_rd  [6];
        int got = 0;
        logic acc;
        exp_err = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_rd  = '{32'h0, 32'h11, 32'h0, 32'h0, 32'h22, 32'h22};
        do_reset();
        send(1'b1, 4'd0, 32'h11);
        wait_resp();
        send(1'b0, 4'd0, 32'h0);
        send(1'b1, 4'd7, 32'h99);
        send(1'b1, 4'd0, 32'h22);
        send(1'b0, 4'd0, 32'h0);
        vecs++;
        if (req_ready !== 1'b0) begin
            errs++;
            $display("FAIL full_ready got %b required 0", req_ready);
        end
        req_valid = 1'b1; req_write = 1'b0; req_thread_id = 4'd0; req_wdata = 32'h0;
        tick(); tick(); tick();
        vecs++;
        if ({req_ready, resp_valid, resp_err, resp_rdata} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
            errs++;
            $display("FAIL stall_hold ready=%b valid=%b err=%b rdata=%h required 0 1 0 0",
                     req_ready, resp_valid, resp_err, resp_rdata);
        end
        resp_ready = 1'b1;
        for (int c = 0; c < 80 && got < 6; c++) begin
            acc = req_valid & req_ready;
            if (resp_valid) begin
                vecs++;
                if ({resp_err, resp_rdata} !== {exp_err[got], exp_rd[got]}) begin
                    errs++;
                    $display("FAIL order%0d err=%b rdata=%h required %b %h",
                             got, resp_err, resp_rdata, exp_err[got], exp_rd[got]);
                end
                got++;
            end
            tick();
            if (acc) req_valid = 1'b0;
        end
        vecs++;
        if (got != 6) begin
            errs++;
            $display("FAIL order_count got %0d required 6", got);
        end
        req_valid = 1'b0;
        resp_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int t [3];
        int got = 0;
        int s0;
        do_reset();
        s0 = strobes;
        resp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_thread_id = 4'd0; req_wdata = 32'h5A5A5A5A;
        tick();
        req_write = 1'b0;
        tick();
        tick();
        req_valid = 1'b0;
        for (int c = 3; c < 30; c++) begin
            if (resp_valid && got < 3) begin
                t[got] = c;
                vecs++;
                if (got > 0 && resp_rdata !== 32'h5A5A5A5A) begin
                    errs++;
                    $display("FAIL b2b_rdata%0d got %h required 5a5a5a5a", got, resp_rdata);
                end
                got++;
            end
            tick();
        end
        vecs++;
        if (got != 3 || t[0] != 4 || t[1] != 8 || t[2] != 12 || strobes != s0 + 3) begin
            errs++;
            $display("FAIL b2b_timing resps=%0d cycles=%0d,%0d,%0d strobes=%0d required 3 4,8,12 %0d",
                     got, t[0], t[1], t[2], strobes - s0, 3);
        end
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_in_wait;
        int s0;
        do_reset();
        send(1'b1, 4'd9, 32'h0);
        wait_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_thread_id = 4'd0; req_wdata = 32'h0;
        tick(); tick(); tick();
        req_valid = 1'b0;
        vecs++;
        if ({resp_valid, reg_access_en, viol_count} !== {1'b0, 1'b0, 8'd1}) begin
            errs++;
            $display("FAIL wait_state valid=%b en=%b viol=%0d required 0 0 1", resp_valid, reg_access_en, viol_count);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vecs++;
        if ({resp_valid, viol_count, locked, req_ready} !== {1'b0, 8'd0, 1'b0, 1'b1}) begin
            errs++;
            $display("FAIL rst_wait valid=%b viol=%0d locked=%b ready=%b required 0 0 0 1",
                     resp_valid, viol_count, locked, req_ready);
        end
        s0 = strobes;
        for (int c = 0; c < 10; c++) tick();
        vecs++;
        if (strobes !== s0 || resp_valid !== 1'b0) begin
            errs++;
            $display("FAIL rst_flush strobes=%0d valid=%b required %0d 0", strobes, resp_valid, s0);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_wdata = '0;
        req_thread_id = '0; resp_ready = 1'b0;
        tick();
        test_reset();
        test_authorised();
        test_denied();
        test_lockout();
        test_fifo_full();
        test_back_to_back();
        test_reset_in_wait();
        vecs++;
        if (bad_strobes != 0) begin
            errs++;
            $display("FAIL quiet_strobe got %0d required 0", bad_strobes);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
